// File: rtl/bicubic_pkg.sv
// Shared types and constants for the bicubic interpolation controller.
// Configuration macro: BICUBIC_ZERO_FRAC_BYPASS_EN (see bicubic_ctrl.sv).
package bicubic_pkg;

    localparam int unsigned NUM_TAPS   = 4;
    localparam int unsigned NUM_PASSES = 5;

    // Neighbour fetched when both fractions are zero and the bypass is built in
    localparam logic [1:0] BYPASS_ROW = 2'd1;
    localparam logic [1:0] BYPASS_COL = 2'd1;

    // Engine phase encodings: 0 loads weights / computes output, 1..4 carry sample k-1
    localparam logic [2:0] PH_LOAD  = 3'd0;
    localparam logic [2:0] PH_TAP0  = 3'd1;

    typedef logic [7:0] q0_8_t;
    typedef logic [7:0] q8_0_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_LOADX = 3'd2,
        S_FETCH = 3'd3,
        S_FEED  = 3'd4,
        S_DRAIN = 3'd5,
        S_CAPT  = 3'd6
    } state_t;

    // Engine weight vector, t^3 in the low byte
    typedef struct packed {
        q0_8_t t;
        q0_8_t t2;
        q0_8_t t3;
    } pow_t;

    // Engine phase code for tap index k
    function automatic logic [2:0] tap_phase(input logic [1:0] k);
        return PH_TAP0 + 3'(k);
    endfunction

endpackage

// File: rtl/bicubic_ctrl_frac_pow.sv
// Combinational powers of a Q0.8 fraction: {t, t^2, t^3}, each rounded to Q0.8.
module frac_pow
    import bicubic_pkg::*;
(
    input  logic [7:0]  i_t,
    output logic [23:0] o_pow
);

    logic [15:0] w_sq;
    logic [15:0] w_cube;
    logic [7:0]  w_t2;
    logic [7:0]  w_t3;

    // Round-to-nearest products kept in 16 bits (max 255*255+128 fits)
    assign w_sq   = 16'(i_t) * 16'(i_t) + 16'd128;
    assign w_t2   = 8'(w_sq >> 8);
    assign w_cube = 16'(w_t2) * 16'(i_t) + 16'd128;
    assign w_t3   = 8'(w_cube >> 8);
    assign o_pow  = {i_t, w_t2, w_t3};

endmodule

// File: rtl/bicubic_ctrl.sv
// Bicubic interpolation sequencer: four horizontal passes over a 4x4
// neighbourhood followed by one vertical pass over the intermediate results,
// driving an external cubic engine through the eng_* ports.
// Optional feature: define BICUBIC_ZERO_FRAC_BYPASS_EN to short-circuit
// zero fractions into a single fetch of the anchor pixel.
module bicubic_ctrl
    import bicubic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [7:0]  i_frac_x,
    input  logic [7:0]  i_frac_y,
    output logic        o_pix_req,
    output logic [1:0]  o_pix_row,
    output logic [1:0]  o_pix_col,
    input  logic        i_pix_ack,
    input  logic [7:0]  i_pix_data,
    output logic [23:0] o_eng_x,
    output logic [7:0]  o_eng_p,
    output logic [2:0]  o_eng_cnt,
    input  logic [7:0]  i_eng_out,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_result
);

    state_t      r_state;
    logic [2:0]  r_pass;
    logic [1:0]  r_tap;
    logic        r_bypass;
    q0_8_t       r_frac_x;
    q0_8_t       r_frac_y;
    pow_t        r_wx;
    pow_t        r_wy;
    pow_t        r_eng_x;
    q8_0_t       r_eng_p;
    logic [2:0]  r_eng_cnt;
    logic        r_pix_req;
    logic [1:0]  r_pix_row;
    logic [1:0]  r_pix_col;
    q8_0_t       r_h [NUM_TAPS];
    q8_0_t       r_result;
    logic        r_busy;
    logic        r_done;

    pow_t        w_pow_x;
    pow_t        w_pow_y;
    logic        w_last_pass;
    logic        w_last_tap;
    logic [1:0]  w_next_tap;
    logic        w_bypass_start;

    frac_pow u_pow_x (
        .i_t   (r_frac_x),
        .o_pow (w_pow_x)
    );

    frac_pow u_pow_y (
        .i_t   (r_frac_y),
        .o_pow (w_pow_y)
    );

    assign w_last_pass = (r_pass == 3'(NUM_PASSES - 1));
    assign w_last_tap  = (r_tap == 2'(NUM_TAPS - 1));
    assign w_next_tap  = r_tap + 2'd1;

`ifdef BICUBIC_ZERO_FRAC_BYPASS_EN
    // Zero fractions reduce the interpolation to the anchor pixel itself
    assign w_bypass_start = (i_frac_x == 8'd0) && (i_frac_y == 8'd0);
`else
    assign w_bypass_start = 1'b0;
`endif

    // Sequencer: state, pass/tap counters and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pass    <= '0;
            r_tap     <= '0;
            r_bypass  <= 1'b0;
            r_frac_x  <= '0;
            r_frac_y  <= '0;
            r_wx      <= '0;
            r_wy      <= '0;
            r_eng_x   <= '0;
            r_eng_p   <= '0;
            r_eng_cnt <= PH_LOAD;
            r_pix_req <= 1'b0;
            r_pix_row <= '0;
            r_pix_col <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_h[i] <= '0;
            end
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_frac_x <= i_frac_x;
                        r_frac_y <= i_frac_y;
                        r_pass   <= '0;
                        r_tap    <= '0;
                        r_busy   <= 1'b1;
                        if (w_bypass_start) begin
                            r_bypass  <= 1'b1;
                            r_pix_req <= 1'b1;
                            r_pix_row <= BYPASS_ROW;
                            r_pix_col <= BYPASS_COL;
                            r_state   <= S_FETCH;
                        end else begin
                            r_state <= S_PREP;
                        end
                    end
                end

                S_PREP: begin
                    r_wx      <= w_pow_x;
                    r_wy      <= w_pow_y;
                    r_eng_x   <= w_pow_x;
                    r_eng_cnt <= PH_LOAD;
                    r_state   <= S_LOADX;
                end

                S_LOADX: begin
                    r_tap <= '0;
                    if (w_last_pass) begin
                        r_eng_p   <= r_h[0];
                        r_eng_cnt <= tap_phase(2'd0);
                        r_state   <= S_FEED;
                    end else begin
                        r_pix_req <= 1'b1;
                        r_pix_row <= r_pass[1:0];
                        r_pix_col <= 2'd0;
                        r_state   <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (i_pix_ack) begin
                        r_pix_req <= 1'b0;
                        r_eng_p   <= i_pix_data;
                        if (r_bypass) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_eng_cnt <= tap_phase(r_tap);
                            r_state   <= S_FEED;
                        end
                    end
                end

                S_FEED: begin
                    if (w_last_tap) begin
                        r_eng_cnt <= PH_LOAD;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_tap <= w_next_tap;
                        if (w_last_pass) begin
                            r_eng_p   <= r_h[w_next_tap];
                            r_eng_cnt <= tap_phase(w_next_tap);
                        end else begin
                            r_eng_cnt <= PH_LOAD;
                            r_pix_req <= 1'b1;
                            r_pix_col <= w_next_tap;
                            r_state   <= S_FETCH;
                        end
                    end
                end

                S_DRAIN: begin
                    // Engine output is captured on entry to CAPT so it is visible with done
                    r_state <= S_CAPT;
                    if (r_bypass) begin
                        r_result <= r_eng_p;
                        r_done   <= 1'b1;
                    end else if (w_last_pass) begin
                        r_result <= i_eng_out;
                        r_done   <= 1'b1;
                    end else begin
                        r_h[r_pass[1:0]] <= i_eng_out;
                    end
                end

                S_CAPT: begin
                    r_tap <= '0;
                    if (r_bypass || w_last_pass) begin
                        r_bypass <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_pass  <= r_pass + 3'd1;
                        r_eng_x <= (r_pass == 3'(NUM_PASSES - 2)) ? r_wy : r_wx;
                        r_state <= S_LOADX;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_pix_req = r_pix_req;
    assign o_pix_row = r_pix_row;
    assign o_pix_col = r_pix_col;
    assign o_eng_x   = r_eng_x;
    assign o_eng_p   = r_eng_p;
    assign o_eng_cnt = r_eng_cnt;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_result  = r_result;

endmodule

// File: tb/tb_bicubic_ctrl.sv
// Directed bench for bicubic_ctrl with a pixel-memory responder and a
// Catmull-Rom engine model attached to the eng_* ports.
module tb_bicubic_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_frac_x = 8'd0;
    logic [7:0]  i_frac_y = 8'd0;
    logic        o_pix_req;
    logic [1:0]  o_pix_row;
    logic [1:0]  o_pix_col;
    logic        i_pix_ack = 1'b0;
    logic [7:0]  i_pix_data = 8'd0;
    logic [23:0] o_eng_x;
    logic [7:0]  o_eng_p;
    logic [2:0]  o_eng_cnt;
    logic [7:0]  i_eng_out;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_result;

    bicubic_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_frac_x   (i_frac_x),
        .i_frac_y   (i_frac_y),
        .o_pix_req  (o_pix_req),
        .o_pix_row  (o_pix_row),
        .o_pix_col  (o_pix_col),
        .i_pix_ack  (i_pix_ack),
        .i_pix_data (i_pix_data),
        .o_eng_x    (o_eng_x),
        .o_eng_p    (o_eng_p),
        .o_eng_cnt  (o_eng_cnt),
        .i_eng_out  (i_eng_out),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int s_cyc = 0;

    logic [7:0] img [4][4];
    int ack_delay = 0;
    int wcnt = 0;

    // Pixel memory: acknowledges after ack_delay wait cycles
    always @(negedge clk) begin
        if (o_pix_req && wcnt >= ack_delay) begin
            i_pix_ack  <= 1'b1;
            i_pix_data <= img[o_pix_row][o_pix_col];
            wcnt       <= 0;
        end else begin
            i_pix_ack <= 1'b0;
            wcnt      <= o_pix_req ? wcnt + 1 : 0;
        end
    end

    // Engine model: Catmull-Rom cubic with weights {t, t^2, t^3}
    logic [23:0] em_x = 24'd0;
    int          em_p [4];

    function automatic logic [7:0] cubic(input logic [23:0] x, input int p0, input int p1,
                                         input int p2, input int p3);
        int t, t2, t3, acc, o;
        t   = int'(x[23:16]);
        t2  = int'(x[15:8]);
        t3  = int'(x[7:0]);
        acc = 512 * p1 + t * (p2 - p0) + t2 * (2 * p0 - 5 * p1 + 4 * p2 - p3)
            + t3 * (3 * p1 - p0 - 3 * p2 + p3);
        o   = (acc + 256) >>> 9;
        if (o < 0) o = 0;
        if (o > 255) o = 255;
        return 8'(o);
    endfunction

    always @(posedge clk) begin
        if (o_eng_cnt == 3'd0) em_x <= o_eng_x;
        else if (o_eng_cnt <= 3'd4) em_p[int'(o_eng_cnt) - 1] <= int'(o_eng_p);
    end

    always_comb i_eng_out = cubic(em_x, em_p[0], em_p[1], em_p[2], em_p[3]);

    // Monitor: accepted requests, done pulses, engine weight log per fed sample
    int          req_n = 0;
    int          done_n = 0;
    int          ex_n = 0;
    int          ack_cyc = 0;
    logic [1:0]  req_row [256];
    logic [1:0]  req_col [256];
    logic [23:0] ex_log [512];

    always @(posedge clk) begin
        if (o_pix_req && i_pix_ack) begin
            if (req_n < 256) begin
                req_row[req_n] <= o_pix_row;
                req_col[req_n] <= o_pix_col;
            end
            req_n   <= req_n + 1;
            ack_cyc <= cyc;
        end
        if (o_done) done_n <= done_n + 1;
        if (o_eng_cnt != 3'd0) begin
            if (ex_n < 512) ex_log[ex_n] <= o_eng_x;
            ex_n <= ex_n + 1;
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_const(input logic [7:0] v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[r][c] = v;
    endtask

    // Pixel (r,c) = 20r + 40c + 10
    task automatic set_ramp();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[r][c] = 8'(20 * r + 40 * c + 10);
    endtask

    // Called at #1 after an edge while the DUT is idle; start is high for one cycle
    task automatic launch(input logic [7:0] fx, input logic [7:0] fy);
        i_frac_x = fx;
        i_frac_y = fy;
        i_start  = 1'b1;
        s_cyc    = cyc;
        @(posedge clk);
        #1;
        i_start  = 1'b0;
    endtask

    // Returns cycles from start cycle to done cycle, -1 on timeout; optional stray start
    task automatic wait_done(input int stray, output int lat);
        lat = -1;
        for (int g = 0; g < 400; g++) begin
            if (o_done) begin
                lat = cyc - s_cyc;
                break;
            end
            i_start = ((cyc - s_cyc) == stray);
            @(posedge clk);
            #1;
            i_start = 1'b0;
        end
    endtask

    function automatic int seq_bad(input int base);
        int bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (req_row[base + i] !== 2'(i / 4) || req_col[base + i] !== 2'(i % 4)) bad++;
        end
        return bad;
    endfunction

    function automatic int ex_bad(input int base, input logic [23:0] wx, input logic [23:0] wy);
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (ex_log[base + i] !== ((i < 16) ? wx : wy)) bad++;
        end
        return bad;
    endfunction

    int lat;
    int rb, db, eb;
    logic [7:0] r1;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    32'(o_busy),    32'd0);
        chk("rst_done",    32'(o_done),    32'd0);
        chk("rst_pix_req", 32'(o_pix_req), 32'd0);
        chk("rst_result",  32'(o_result),  32'd0);
        chk("rst_eng_cnt", 32'(o_eng_cnt), 32'd0);
        chk("rst_eng_x",   32'(o_eng_x),   32'd0);
        chk("rst_eng_p",   32'(o_eng_p),   32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Constant 100 image, half-pel fractions, immediate ack
        set_const(8'd100);
        ack_delay = 0;
        rb = req_n; db = done_n; eb = ex_n;
        launch(8'd128, 8'd128);
        wait_done(-1, lat);
        chk("const_latency", 32'(lat), 32'd52);
        chk("const_result_window", 32'(o_result >= 8'd99 && o_result <= 8'd101), 32'd1);
        chk("const_busy_at_done", 32'(o_busy), 32'd1);
        r1 = o_result;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        chk("done_one_cycle", 32'(o_done), 32'd0);
        @(posedge clk);
        #1;
        chk("start_in_done_cycle_ignored", 32'(o_busy), 32'd0);
        chk("const_req_count", 32'(req_n - rb), 32'd16);
        chk("const_req_order", 32'(seq_bad(rb)), 32'd0);
        chk("const_feed_count", 32'(ex_n - eb), 32'd20);
        chk("const_weights_128", 32'(ex_bad(eb, 24'h804020, 24'h804020)), 32'd0);
        chk("const_done_count", 32'(done_n - db), 32'd1);

        // Same stimulus, three wait cycles per request
        ack_delay = 3;
        rb = req_n;
        launch(8'd128, 8'd128);
        wait_done(-1, lat);
        chk("slow_ack_latency", 32'(lat), 32'd100);
        chk("slow_ack_result", 32'(o_result), 32'(r1));
        chk("slow_ack_req_count", 32'(req_n - rb), 32'd16);
        ack_delay = 0;
        @(posedge clk);
        #1;

        // Ramp, horizontal half-pel only; stray start at cycle 10 ignored
        set_ramp();
        db = done_n; eb = ex_n;
        launch(8'd128, 8'd0);
        wait_done(10, lat);
        chk("ramp_h_latency", 32'(lat), 32'd52);
        chk("ramp_h_result", 32'(o_result), 32'd90);
        chk("ramp_h_weights", 32'(ex_bad(eb, 24'h804020, 24'h000000)), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("stray_start_one_done", 32'(done_n - db), 32'd1);
        chk("stray_start_idle", 32'(o_busy), 32'd0);

        // Ramp, vertical half-pel only
        launch(8'd0, 8'd128);
        wait_done(-1, lat);
        chk("ramp_v_result", 32'(o_result), 32'd80);
        @(posedge clk);
        #1;

        // Maximum fractions on a constant image, then back-to-back start
        set_const(8'd200);
        eb = ex_n;
        launch(8'd255, 8'd255);
        wait_done(-1, lat);
        chk("max_frac_result", 32'(o_result), 32'd200);
        chk("max_frac_weights", 32'(ex_bad(eb, 24'hFFFEFD, 24'hFFFEFD)), 32'd0);
        @(posedge clk);
        #1;
        launch(8'd128, 8'd128);
        chk("back_to_back_accepted", 32'(o_busy), 32'd1);
        wait_done(-1, lat);
        chk("back_to_back_latency", 32'(lat), 32'd52);
        @(posedge clk);
        #1;

        // Reset in the middle of an operation
        set_ramp();
        launch(8'd128, 8'd0);
        while ((cyc - s_cyc) < 20) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        db = done_n;
        chk("midrst_busy",    32'(o_busy),    32'd0);
        chk("midrst_pix_req", 32'(o_pix_req), 32'd0);
        chk("midrst_result",  32'(o_result),  32'd0);
        chk("midrst_eng_cnt", 32'(o_eng_cnt), 32'd0);
        repeat (80) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_n - db), 32'd0);
        launch(8'd128, 8'd0);
        wait_done(-1, lat);
        chk("post_rst_latency", 32'(lat), 32'd52);
        chk("post_rst_result", 32'(o_result), 32'd90);
        @(posedge clk);
        #1;

        // Zero fractions: anchor pixel 77
        set_const(8'd5);
        img[1][1] = 8'd77;
        rb = req_n; eb = ex_n;
        launch(8'd0, 8'd0);
        wait_done(-1, lat);
        chk("zero_frac_result", 32'(o_result), 32'd77);
`ifdef BICUBIC_ZERO_FRAC_BYPASS_EN
        chk("bypass_req_count", 32'(req_n - rb), 32'd1);
        chk("bypass_req_row", 32'(req_row[rb]), 32'd1);
        chk("bypass_req_col", 32'(req_col[rb]), 32'd1);
        chk("bypass_ack_to_done", 32'(cyc - ack_cyc), 32'd2);
        chk("bypass_engine_idle", 32'(ex_n - eb), 32'd0);
`else
        chk("zero_frac_req_count", 32'(req_n - rb), 32'd16);
        chk("zero_frac_latency", 32'(lat), 32'd52);
        chk("zero_frac_feed_count", 32'(ex_n - eb), 32'd20);
`endif
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bicubic_ctrl.md
BICUBIC_CTRL -- requirements
Module: bicubic_ctrl

Interface
REQ-001 The block SHALL have a clock input clk (1 bit); all state updates occur on its rising edge.
REQ-002 The block SHALL have a reset input rst (1 bit); reset rst is synchronous and active-high.
REQ-003 start, input, 1 bit, SHALL request one interpolated pixel; it is sampled only in IDLE.
REQ-004 frac_x, frac_y, inputs, 8 bits each, SHALL be the Q0.8 fractional positions; they are latched when start is accepted.
REQ-005 pix_req, output, 1 bit, SHALL request the neighbourhood pixel at pix_row/pix_col.
REQ-006 pix_row, pix_col, outputs, 2 bits each, SHALL give the neighbour offset; code 0..3 means -1..+2 relative to the anchor.
REQ-007 pix_ack, input, 1 bit, SHALL complete a pixel request; pix_data (input, 8 bits, Q8.0) is valid in the pix_ack cycle.
REQ-008 eng_x, output, 24 bits, SHALL drive the engine weight vector {t, t^2, t^3}, with t^3 in the low byte.
REQ-009 eng_p, output, 8 bits, SHALL drive the engine sample.
REQ-010 eng_cnt, output, 3 bits, SHALL drive the engine phase (0 = load weights/compute output, 1..4 = sample k-1).
REQ-011 eng_out, input, 8 bits, SHALL carry the engine's clamped result.
REQ-012 busy, output, 1 bit, SHALL be high in every state except IDLE.
REQ-013 done, output, 1 bit, SHALL be a one-cycle completion pulse.
REQ-014 result, output, 8 bits, SHALL be the interpolated pixel; it holds until the next done.

Function
REQ-015 The FSM SHALL have states IDLE, PREP, LOADX, FETCH, FEED, DRAIN, CAPT.
- IDLE -> PREP on start.
- PREP -> LOADX.
- LOADX -> FETCH (horizontal pass) or FEED (vertical pass).
- FETCH -> FEED on pix_ack.
- FEED -> FETCH/FEED for next sample, or DRAIN after sample 4.
- DRAIN -> CAPT.
- CAPT -> LOADX for the next pass, or IDLE after pass 5.
REQ-016 PREP SHALL compute t2=(t*t+128)>>8 and t3=(t2*t+128)>>8, 16-bit intermediates, for both fractions.
REQ-017 Passes 0..3 SHALL be horizontal: weights from frac_x; samples fetched at pix_row=pass, pix_col=0..3 in order.
REQ-018 Pass 4 SHALL be vertical: weights from frac_y; samples h[0..3] from internal registers, with no fetch.
REQ-019 Per pass, eng_cnt SHALL be 0 in LOADX, k in FEED of sample k, and 0 in DRAIN.
REQ-020 CAPT SHALL store eng_out into h[pass] (passes 0..3) or into result (pass 4).
REQ-021 eng_x SHALL be held stable for the whole pass.
REQ-022 pix_data SHALL be latched in FETCH on pix_ack; eng_p SHALL present the latched value in FEED.
REQ-023 pix_req SHALL be high only in FETCH; pix_row/pix_col SHALL be stable while pix_req is high.
REQ-024 FETCH SHALL hold indefinitely without pix_ack; eng_cnt SHALL be 0 while in FETCH.
REQ-025 done SHALL pulse in the CAPT of pass 4; result SHALL be updated in the same cycle.
REQ-026 Latency with pix_ack held high SHALL be exactly 52 cycles from the start-accept edge to done; each FETCH wait cycle SHALL add 1.
REQ-027 start while busy SHALL be ignored; start in the cycle done pulses SHALL be ignored.
REQ-028 Back-to-back start is accepted from the first IDLE cycle.

Reset
REQ-029 On rst the FSM SHALL go to IDLE, including mid-operation, with no done pulse.
REQ-030 On rst: pix_req=0, busy=0, done=0, result=0, eng_cnt=0, eng_x=0, eng_p=0, h[0..3]=0.

Configuration
REQ-031 With BICUBIC_ZERO_FRAC_BYPASS_EN defined, start with frac_x==0 and frac_y==0 SHALL fetch only pix_row=1, pix_col=1 and set result=pix_data.
- done SHALL pulse 2 cycles after pix_ack.
- The engine SHALL be left idle (eng_cnt=0).
REQ-032 Without BICUBIC_ZERO_FRAC_BYPASS_EN, zero fractions SHALL run the full 5-pass sequence.

Structure
REQ-033 Package bicubic_pkg SHALL hold the FSM state enum, the Q0.8/Q8.0 typedefs, NUM_TAPS=4, NUM_PASSES=5 and the phase encodings.
REQ-034 Sub-module frac_pow SHALL compute {t, t2, t3} combinationally; the engine SHALL remain external, connected through the eng_* ports.

Verification
REQ-035 Constant image of 100, frac_x=frac_y=128, pix_ack tied high -> done at cycle 52, result within +-1 of 100.
REQ-036 The same stimulus SHALL produce the pix_row/pix_col sequence (0,0),(0,1)..(3,3): exactly 16 requests, none in pass 4.
REQ-037 pix_ack delayed 3 cycles per request -> done at cycle 100, result identical to REQ-035.
REQ-038 start pulsed at cycle 10 during operation -> ignored; exactly one done.
REQ-039 rst at cycle 20 -> next cycle busy=0, pix_req=0, result=0; a new start completes normally.
REQ-040 With the macro, frac 0/0 and pixel(1,1)=77 -> one request, result=77, done 2 cycles after pix_ack; without the macro -> 16 requests.
